// File: rtl/multicycle_controller.sv
// Main FSM and ALU decoder for the multicycle RV32I core, one state per cycle.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes / unsupported ALU func3 trap into HALT and raise 'illegal'.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       Zero,
  input  logic       lt,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl
`ifdef ILLEGAL_TRAP_EN
  , output logic     illegal
`endif
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXER, EXEI,
    ALUWB, BRANCH, JAL, JALR, LINK, LUI, HALT
  } state_t;

  state_t state, next_state;

  logic       pc_write_raw, ir_write_raw, reg_write_raw, mem_write_raw;
  logic       func3_ok;
  logic [2:0] alu_op_decoded;
  logic       branch_taken;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  // ALU operation for EXER/EXEI; SUB only exists for R-type with func7 = 0100000.
  always_comb begin
    func3_ok       = 1'b1;
    alu_op_decoded = 3'b000;
    case (func3)
      3'b000:  alu_op_decoded = (state == EXER && func7 == 7'b0100000) ? 3'b001 : 3'b000;
      3'b100:  alu_op_decoded = 3'b100;
      3'b110:  alu_op_decoded = 3'b011;
      3'b111:  alu_op_decoded = 3'b010;
      3'b010:  alu_op_decoded = 3'b101;
      default: func3_ok       = 1'b0;
    endcase
  end

  always_comb begin
    branch_taken = 1'b0;
    case (func3)
      3'b000:  branch_taken = Zero;
      3'b001:  branch_taken = ~Zero;
      3'b100:  branch_taken = lt;
      3'b101:  branch_taken = ~lt;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXER;
          OP_I:         next_state = EXEI;
          OP_BR:        next_state = BRANCH;
          OP_JAL:       next_state = JAL;
          OP_JALR:      next_state = JALR;
          OP_LUI:       next_state = LUI;
`ifdef ILLEGAL_TRAP_EN
          default:      next_state = HALT;
`else
          default:      next_state = FETCH;
`endif
        endcase
      end
      MEMADR:   next_state = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = MEMWB;
      EXER, EXEI: begin
`ifdef ILLEGAL_TRAP_EN
        next_state = func3_ok ? ALUWB : HALT;
`else
        next_state = ALUWB;
`endif
      end
      JAL, JALR: next_state = LINK;
      HALT:      next_state = HALT;
      default:   next_state = FETCH;
    endcase
  end

  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ImmSrc        = 3'b000;
    ALUControl    = 3'b000;
    case (state)
      FETCH: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_SW) ? 3'b001 : 3'b000;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXER: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_op_decoded;
      end
      EXEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_op_decoded;
      end
      ALUWB:  reg_write_raw = 1'b1;
      BRANCH: begin
        ALUSrcA      = 2'b10;
        ALUControl   = 3'b001;
        pc_write_raw = branch_taken;
      end
      JAL:    pc_write_raw = 1'b1;
      JALR: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b01;
        ResultSrc    = 2'b10;
        pc_write_raw = 1'b1;
      end
      LINK: begin
        ALUSrcA       = 2'b01;
        ALUSrcB       = 2'b10;
        ResultSrc     = 2'b10;
        reg_write_raw = 1'b1;
      end
      LUI: begin
        ALUSrcB       = 2'b01;
        ImmSrc        = 3'b100;
        ALUControl    = 3'b111;
        ResultSrc     = 2'b10;
        reg_write_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Write strobes are masked during reset so an aborted instruction cannot commit anything.
  assign PCWrite  = pc_write_raw  & ~rst;
  assign IRWrite  = ir_write_raw  & ~rst;
  assign RegWrite = reg_write_raw & ~rst;
  assign MemWrite = mem_write_raw & ~rst;

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state == HALT) & ~rst;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: vector table, hand sequences, random instructions vs. model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       Zero, lt;
  logic       PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int checks   = 0;
  int failures = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .Zero(Zero), .lt(lt),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  logic [16:0] outs;
  logic [3:0]  strobes;
  assign outs    = {PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
  assign strobes = {PCWrite, IRWrite, RegWrite, MemWrite};

  function automatic logic [16:0] mk(input int pcw, input int adr, input int irw, input int rw,
                                     input int mw, input int rs, input int sa, input int sb,
                                     input int imm, input int alu);
    return {pcw[0], adr[0], irw[0], rw[0], mw[0], rs[1:0], sa[1:0], sb[1:0], imm[2:0], alu[2:0]};
  endfunction

  // Instruction cycle counts, including FETCH and DECODE.
  function automatic int latency(input logic [6:0] o);
    case (o)
      7'h03:                      return 5;
      7'h23, 7'h33, 7'h13, 7'h6F, 7'h67: return 4;
      7'h63, 7'h37:               return 3;
      default:                    return 2;
    endcase
  endfunction

  function automatic int aluOf(input logic [2:0] f3, input logic [6:0] f7, input bit isR);
    case (f3)
      3'b000:  return (isR && f7 == 7'h20) ? 1 : 0;
      3'b100:  return 4;
      3'b110:  return 3;
      3'b111:  return 2;
      3'b010:  return 5;
      default: return 0;
    endcase
  endfunction

  // Expected control word for cycle k of one instruction.
  function automatic logic [16:0] model(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                                        input logic z, input logic l, input int k);
    bit taken;
    taken = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z) || (f3 == 3'b100 && l) || (f3 == 3'b101 && !l);
    if (k == 0) return mk(1,0,1,0,0,2,0,2,0,0);
    if (k == 1) return mk(0,0,0,0,0,0,1,1,(o == 7'h6F) ? 3 : 2,0);
    case (o)
      7'h03: case (k)
               2: return mk(0,0,0,0,0,0,2,1,0,0);
               3: return mk(0,1,0,0,0,0,0,0,0,0);
               default: return mk(0,0,0,1,0,1,0,0,0,0);
             endcase
      7'h23: return (k == 2) ? mk(0,0,0,0,0,0,2,1,1,0) : mk(0,1,0,0,1,0,0,0,0,0);
      7'h33: return (k == 2) ? mk(0,0,0,0,0,0,2,0,0,aluOf(f3,f7,1)) : mk(0,0,0,1,0,0,0,0,0,0);
      7'h13: return (k == 2) ? mk(0,0,0,0,0,0,2,1,0,aluOf(f3,f7,0)) : mk(0,0,0,1,0,0,0,0,0,0);
      7'h63: return mk(taken ? 1 : 0,0,0,0,0,0,2,0,0,1);
      7'h6F: return (k == 2) ? mk(1,0,0,0,0,0,0,0,0,0) : mk(0,0,0,1,0,2,1,2,0,0);
      7'h67: return (k == 2) ? mk(1,0,0,0,0,2,2,1,0,0) : mk(0,0,0,1,0,2,1,2,0,0);
      7'h37: return mk(0,0,0,1,0,2,0,1,4,7);
      default: return 17'h0;
    endcase
  endfunction

  task automatic checkOutput(input string nm, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %05h expected %05h", nm, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                               input logic z, input logic l);
    op = o; func3 = f3; func7 = f7; Zero = z; lt = l;
  endtask

  // Runs one whole instruction from FETCH. chk < 0 compares every cycle with the model,
  // otherwise the FETCH cycle and cycle 'chk' are compared with the table constant.
  task automatic runInstr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                          input logic z, input logic l, input int chk, input logic [16:0] exp,
                          input string nm);
    applyStimulus(o, f3, f7, z, l);
    for (int k = 0; k < latency(o); k++) begin
      @(negedge clk);
      if (chk < 0)        checkOutput($sformatf("%s_c%0d", nm, k), outs, model(o, f3, f7, z, l, k));
      else if (k == 0)    checkOutput({nm, "_fetch"}, outs, mk(1,0,1,0,0,2,0,2,0,0));
      else if (k == chk)  checkOutput(nm, outs, exp);
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [6:0]  o;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        z, l;
    int          cyc;
    logic [16:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tbl[0]  = '{7'h03, 3'b010, 7'h00, 1'b0, 1'b0, 4, mk(0,0,0,1,0,1,0,0,0,0), "lw_memwb"};
    tbl[1]  = '{7'h03, 3'b010, 7'h00, 1'b0, 1'b0, 3, mk(0,1,0,0,0,0,0,0,0,0), "lw_memread"};
    tbl[2]  = '{7'h33, 3'b000, 7'h20, 1'b0, 1'b0, 2, mk(0,0,0,0,0,0,2,0,0,1), "r_sub"};
    tbl[3]  = '{7'h33, 3'b111, 7'h00, 1'b0, 1'b0, 2, mk(0,0,0,0,0,0,2,0,0,2), "r_and"};
    tbl[4]  = '{7'h33, 3'b000, 7'h00, 1'b0, 1'b0, 3, mk(0,0,0,1,0,0,0,0,0,0), "r_aluwb"};
    tbl[5]  = '{7'h63, 3'b000, 7'h00, 1'b1, 1'b0, 2, mk(1,0,0,0,0,0,2,0,0,1), "beq_taken"};
    tbl[6]  = '{7'h63, 3'b000, 7'h00, 1'b0, 1'b0, 2, mk(0,0,0,0,0,0,2,0,0,1), "beq_not"};
    tbl[7]  = '{7'h63, 3'b100, 7'h00, 1'b0, 1'b1, 2, mk(1,0,0,0,0,0,2,0,0,1), "blt_taken"};
    tbl[8]  = '{7'h63, 3'b101, 7'h00, 1'b0, 1'b1, 2, mk(0,0,0,0,0,0,2,0,0,1), "bge_not"};
    tbl[9]  = '{7'h6F, 3'b000, 7'h00, 1'b0, 1'b0, 1, mk(0,0,0,0,0,0,1,1,3,0), "jal_decode"};
    tbl[10] = '{7'h6F, 3'b000, 7'h00, 1'b0, 1'b0, 2, mk(1,0,0,0,0,0,0,0,0,0), "jal_jump"};
    tbl[11] = '{7'h6F, 3'b000, 7'h00, 1'b0, 1'b0, 3, mk(0,0,0,1,0,2,1,2,0,0), "jal_link"};
    tbl[12] = '{7'h67, 3'b000, 7'h00, 1'b0, 1'b0, 2, mk(1,0,0,0,0,2,2,1,0,0), "jalr_jump"};
    tbl[13] = '{7'h37, 3'b000, 7'h00, 1'b0, 1'b0, 2, mk(0,0,0,1,0,2,0,1,4,7), "lui"};
    tbl[14] = '{7'h23, 3'b010, 7'h00, 1'b0, 1'b0, 3, mk(0,1,0,0,1,0,0,0,0,0), "sw_memwrite"};
    tbl[15] = '{7'h23, 3'b010, 7'h00, 1'b0, 1'b0, 2, mk(0,0,0,0,0,0,2,1,1,0), "sw_memadr"};

    // Two reset cycles with no strobes, then FETCH.
    applyStimulus(7'h03, 3'b000, 7'h00, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk); checkOutput("rst_strobes_c0", {13'h0, strobes}, 17'h0);
    @(posedge clk);
    @(negedge clk); checkOutput("rst_strobes_c1", {13'h0, strobes}, 17'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[i]) runInstr(tbl[i].o, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].l, tbl[i].cyc, tbl[i].exp, tbl[i].nm);

    // Abort a lw in MEMWB: no register write, next cycle is FETCH.
    applyStimulus(7'h03, 3'b010, 7'h00, 1'b0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk); checkOutput("abort_memwb_strobes", {13'h0, strobes}, 17'h0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); checkOutput("abort_then_fetch", outs, mk(1,0,1,0,0,2,0,2,0,0));
    // Reset held while in FETCH masks PCWrite/IRWrite.
    rst = 1'b1;
    @(negedge clk); checkOutput("rst_in_fetch_strobes", {13'h0, strobes}, 17'h0);
    @(posedge clk); #1; rst = 1'b0;

    runInstr(7'h13, 3'b100, 7'h00, 1'b0, 1'b0, 2, mk(0,0,0,0,0,0,2,1,0,4), "xori");
    runInstr(7'h13, 3'b000, 7'h20, 1'b0, 1'b0, 2, mk(0,0,0,0,0,0,2,1,0,0), "addi_f7_ignored");

`ifdef ILLEGAL_TRAP_EN
    // Unknown opcode traps: illegal high, strobes low until reset.
    runInstr(7'h7F, 3'b000, 7'h00, 1'b0, 1'b0, 1, mk(0,0,0,0,0,0,1,1,2,0), "illegal_decode");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("halt_outs_%0d", k), outs, 17'h0);
      checkOutput($sformatf("halt_illegal_%0d", k), {16'h0, illegal}, 17'h1);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk); checkOutput("halt_illegal_in_rst", {16'h0, illegal}, 17'h0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); checkOutput("halt_exit_fetch", outs, mk(1,0,1,0,0,2,0,2,0,0));
    @(posedge clk); #1;
`else
    // Unknown opcode is a NOP: DECODE then straight back to FETCH.
    runInstr(7'h7F, 3'b000, 7'h00, 1'b0, 1'b0, -1, 17'h0, "illegal_nop");
    runInstr(7'h33, 3'b011, 7'h00, 1'b0, 1'b0, 2, mk(0,0,0,0,0,0,2,0,0,0), "r_func3_fallback");
`endif

    // Random instruction stream against the model.
    for (int n = 0; n < 300; n++) begin
      logic [6:0] ops[11];
      logic [6:0] o;
      logic [2:0] f3;
      logic [6:0] f7;
      ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h7F, 7'h00, 7'h0F};
`ifdef ILLEGAL_TRAP_EN
      o  = ops[$urandom_range(0, 7)];
      f3 = 3'($urandom_range(0, 7));
      if ((o == 7'h33 || o == 7'h13) && (f3 == 3'b001 || f3 == 3'b011 || f3 == 3'b101)) f3 = 3'b000;
`else
      o  = ops[$urandom_range(0, 10)];
      f3 = 3'($urandom_range(0, 7));
`endif
      f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom_range(0, 127));
      runInstr(o, f3, f7, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 17'h0, $sformatf("rnd%0d_op%02h", n, o));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
